// File: rtl/dmux_stream_if.sv
// Handshake bundle for dmux_stream: one upstream word port and NCH downstream channel ports.
// The master side is the producer/consumer environment; the slave side is the demux itself.
interface dmux_stream_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
);
    logic [WIDTH-1:0]     I;
    logic [SELW-1:0]      SEL;
    logic                 BCAST;
    logic                 I_VALID;
    logic                 I_READY;
    logic [NCH*WIDTH-1:0] A;
    logic [NCH-1:0]       A_VALID;
    logic [NCH-1:0]       A_READY;
    logic                 DROP;
    logic [CNTW-1:0]      DROP_CNT;

    modport master (
        output I, SEL, BCAST, I_VALID, A_READY,
        input  I_READY, A, A_VALID, DROP, DROP_CNT
    );

    modport slave (
        input  I, SEL, BCAST, I_VALID, A_READY,
        output I_READY, A, A_VALID, DROP, DROP_CNT
    );
endinterface

// File: rtl/dmux_stream.sv
// Registered 1-to-NCH demultiplexer with a one-entry holding register per channel,
// all-or-nothing broadcast, and a saturating counter of words addressed past the last channel.
module dmux_stream #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
) (
    input logic          CLK,
    input logic          RST,
    dmux_stream_if.slave bus
);
    logic [NCH*WIDTH-1:0] data_q, data_d;
    logic [NCH-1:0]       valid_q, valid_d;
    logic                 drop_q, drop_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;

    logic [NCH-1:0] free;
    logic [NCH-1:0] sel_hit;
    logic [NCH-1:0] load;
    logic           in_range;
    logic           accept;
    logic           xfer;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // sel_hit is all-zero for SEL >= NCH, which doubles as the out-of-range detect.
    always_comb begin
        free    = '0;
        sel_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            free[c]    = !valid_q[c] || bus.A_READY[c];
            sel_hit[c] = (32'(bus.SEL) == c);
        end
        in_range = |sel_hit;

        if (bus.BCAST)
            accept = &free;
        else if (in_range)
            accept = |(sel_hit & free);
        else
            accept = 1'b1;
    end

    assign bus.I_READY = !RST && accept;
    assign xfer        = bus.I_VALID && bus.I_READY;

    always_comb begin
        load    = '0;
        data_d  = data_q;
        valid_d = valid_q;
        if (xfer)
            load = bus.BCAST ? {NCH{1'b1}} : sel_hit;

        // A reload at the same edge as a drain wins, so the channel stays valid with no bubble.
        for (int c = 0; c < NCH; c++) begin
            if (load[c]) begin
                data_d[c*WIDTH +: WIDTH] = bus.I;
                valid_d[c]               = 1'b1;
            end else if (bus.A_READY[c]) begin
                valid_d[c] = 1'b0;
            end
        end

        drop_d = xfer && !bus.BCAST && !in_range;
        cnt_d  = drop_d ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q  <= '0;
            valid_q <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.A        = data_q;
    assign bus.A_VALID  = valid_q;
    assign bus.DROP     = drop_q;
    assign bus.DROP_CNT = cnt_q;
endmodule
